pb_conditioner: RTL and testbench
=================================

// Module: pb_conditioner
// PURPOSE
//   Parametrised push-button front end: per-channel synchroniser, debouncer and
//   rise/fall edge pulses for WIDTH asynchronous inputs (pb[20:0] at top level).
//   Also produces a registered priority key code for the first rising channel.
//   The key code feeds the display decoders and counters in top.
// PARAMETERS
//   WIDTH           21  number of button channels (>=2)
//   SYNC_STAGES     2   synchroniser flops per channel (>=2)
//   DEBOUNCE_CYCLES 10  consecutive disagreeing cycles needed to accept a new level (>=1)
//   (localparams: CNT_W = $clog2(DEBOUNCE_CYCLES+1), CODE_W = $clog2(WIDTH))
// PORTS
//   hwclk       in   1       system clock
//   reset       in   1       synchronous, active-high reset
//   pb          in   WIDTH   raw asynchronous button inputs, active-high
//   pb_level    out  WIDTH   debounced level per channel
//   pb_rise     out  WIDTH   1-cycle pulse when pb_level[i] goes 0->1
//   pb_fall     out  WIDTH   1-cycle pulse when pb_level[i] goes 1->0
//   key_strobe  out  1       1-cycle pulse: at least one rise in the previous cycle
//   key_code    out  CODE_W  lowest channel index that rose; held between strobes
//   key_multi   out  1       valid with key_strobe: more than one channel rose together
// BEHAVIOUR
//   - Reset: every synchroniser flop, counter, pb_level, pb_rise, pb_fall, key_strobe,
//     key_code and key_multi is 0 after the first hwclk edge with reset=1.
//     Reset wins over all other activity, including a debounce count in progress.
//   - Sync: a SYNC_STAGES-deep flop chain per channel gives sync[i].
//   - Debounce, per channel, with counter cnt[i] of CNT_W bits:
//       sync[i]==pb_level[i]                       -> cnt[i]<=0
//       sync[i]!=pb_level[i] && cnt[i]<DEBOUNCE_CYCLES-1 -> cnt[i]<=cnt[i]+1
//       sync[i]!=pb_level[i] && cnt[i]==DEBOUNCE_CYCLES-1 -> pb_level[i]<=sync[i], cnt[i]<=0
//     A disagreement shorter than DEBOUNCE_CYCLES cycles resets the count and leaves
//     the level unchanged. The counter never wraps.
//   - Latency: pb[i] changes and is first sampled at edge 1. It then stays stable.
//     pb_level[i] shows the new value after edge SYNC_STAGES+DEBOUNCE_CYCLES.
//     With DEBOUNCE_CYCLES=1, pb_level follows sync[i] one cycle later.
//   - Edges: pb_rise/pb_fall are registered from the next-level computation. Each is
//     high during exactly the first cycle in which pb_level shows the new value.
//     They are mutually exclusive per channel. A rise and a fall on different
//     channels in the same cycle are both reported.
//   - Key encoder (registered, one cycle after pb_rise):
//       key_strobe <= |pb_rise
//       key_code   <= lowest i with pb_rise[i]=1 (updates only when |pb_rise)
//       key_multi  <= (popcount(pb_rise)>1) when |pb_rise, else 0
//     Falls never generate key_strobe.
//   - Reset release with a button held: pb_level starts at 0. The held button then
//     produces one rise SYNC_STAGES+DEBOUNCE_CYCLES cycles later, like a fresh press.
//   - Channels are fully independent. Same-cycle changes on many channels must not
//     interact, apart from the key priority encoding.
// TESTING  (bench parameters: WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
//   1. Clean press: pb[3] 0->1 and held. pb_level[3]=1 after edge 6. pb_rise[3]=1 for
//      one cycle. The next cycle has key_strobe=1, key_code=3, key_multi=0.
//   2. Glitch: pb[0] high for 3 cycles, then low. pb_level, pb_rise, pb_fall and
//      key_strobe all stay 0.
//   3. Bounce: pb[1] toggles 1,0,1,1,0,1 on successive cycles, then stays 1. Exactly
//      one pb_rise[1] and one key_strobe occur, and pb_fall[1] never fires.
//   4. Simultaneous: pb[5] and pb[2] rise on the same edge. pb_rise=8'h24 for one cycle.
//      The next cycle has key_strobe=1, key_code=2, key_multi=1.
//   5. Release: after test 1, pb[3] goes to 0. pb_fall[3] pulses once, 6 cycles later.
//      key_strobe stays 0 and key_code holds 3.
//   6. Reset mid-count: assert reset when cnt[4]=2. All outputs are 0 on the next cycle.
//      With pb[4] held through the reset release, pb_rise[4] fires 6 cycles after
//      release.

Source files
------------

// File: rtl/pb_conditioner.sv
// pb_conditioner: push-button front end for WIDTH asynchronous inputs.
// Each channel is synchronised, debounced and edge-detected. A registered
// priority encoder reports the lowest channel that rose.
//
// Ports:
//   hwclk      - system clock
//   reset      - synchronous, active-high reset
//   pb         - raw asynchronous button inputs, active-high
//   pb_level   - debounced level per channel
//   pb_rise    - one-cycle pulse when pb_level[i] goes 0->1
//   pb_fall    - one-cycle pulse when pb_level[i] goes 1->0
//   key_strobe - one-cycle pulse, at least one rise in the previous cycle
//   key_code   - lowest channel index that rose, held between strobes
//   key_multi  - valid with key_strobe, more than one channel rose together
module pb_conditioner #(
    parameter int unsigned WIDTH           = 21,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 10,
    localparam int unsigned CNT_W          = $clog2(DEBOUNCE_CYCLES + 1),
    localparam int unsigned CODE_W         = $clog2(WIDTH)
) (
    input  logic              hwclk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  pb,
    output logic [WIDTH-1:0]  pb_level,
    output logic [WIDTH-1:0]  pb_rise,
    output logic [WIDTH-1:0]  pb_fall,
    output logic              key_strobe,
    output logic [CODE_W-1:0] key_code,
    output logic              key_multi
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]                  level_q, level_d;
    logic [WIDTH-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                  fall_q, fall_d;
    logic                              strobe_q, strobe_d;
    logic [CODE_W-1:0]                 code_q, code_d;
    logic                              multi_q, multi_d;
    logic [WIDTH-1:0]                  sync;

    assign sync = sync_q[SYNC_STAGES-1];

    // Synchroniser chains: stage 0 samples the raw pins.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= pb;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
    // disagreeing cycles; any agreement restarts the count.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d[i] = sync[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    // Key encoder works from the registered rise pulses, so it lags by one cycle.
    always_comb begin
        strobe_d = |rise_q;
        code_d   = code_q;
        multi_d  = 1'b0;
        if (|rise_q) begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (rise_q[i]) begin
                    code_d = CODE_W'(i);
                end
            end
            // Clearing the lowest set bit leaves something iff two or more were set.
            multi_d = |(rise_q & (rise_q - WIDTH'(1)));
        end
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            cnt_q    <= '0;
            level_q  <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            strobe_q <= 1'b0;
            code_q   <= '0;
            multi_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            strobe_q <= strobe_d;
            code_q   <= code_d;
            multi_q  <= multi_d;
        end
    end

    assign pb_level   = level_q;
    assign pb_rise    = rise_q;
    assign pb_fall    = fall_q;
    assign key_strobe = strobe_q;
    assign key_code   = code_q;
    assign key_multi  = multi_q;

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner with WIDTH=8, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4. A vector table covers press and release of channel 3;
// hand-written sequences cover glitch, bounce, simultaneous press and a
// reset during a debounce count.
module tb_pb_conditioner;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned SYNC   = 2;
    localparam int unsigned DEB    = 4;
    localparam int unsigned CODE_W = 3;

    logic              hwclk = 1'b0;
    logic              reset = 1'b1;
    logic [WIDTH-1:0]  pb    = '0;
    logic [WIDTH-1:0]  pb_level, pb_rise, pb_fall;
    logic              key_strobe, key_multi;
    logic [CODE_W-1:0] key_code;

    int n_chk  = 0;
    int n_fail = 0;

    pb_conditioner #(
        .WIDTH          (WIDTH),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .hwclk     (hwclk),
        .reset     (reset),
        .pb        (pb),
        .pb_level  (pb_level),
        .pb_rise   (pb_rise),
        .pb_fall   (pb_fall),
        .key_strobe(key_strobe),
        .key_code  (key_code),
        .key_multi (key_multi)
    );

    always #5 hwclk = ~hwclk;

    typedef struct packed {
        logic              rst;
        logic [WIDTH-1:0]  pb;
        logic [WIDTH-1:0]  level;
        logic [WIDTH-1:0]  rise;
        logic [WIDTH-1:0]  fall;
        logic              strobe;
        logic [CODE_W-1:0] code;
        logic              multi;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic r, input logic [WIDTH-1:0] p);
        reset = r;
        pb    = p;
        @(posedge hwclk);
        #1;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, " level"},  32'(pb_level),   32'(v.level));
        chk({tag, " rise"},   32'(pb_rise),    32'(v.rise));
        chk({tag, " fall"},   32'(pb_fall),    32'(v.fall));
        chk({tag, " strobe"}, 32'(key_strobe), 32'(v.strobe));
        chk({tag, " code"},   32'(key_code),   32'(v.code));
        chk({tag, " multi"},  32'(key_multi),  32'(v.multi));
    endtask

    initial begin
        int rises, falls, strobes;
        logic [CODE_W-1:0] seen_code;

        // Press pb[3] (edges 1..8), then release it (edges 1..7 after change).
        vecs[0] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0};
        for (int i = 1; i <= 5; i++)
            vecs[i] = '{1'b0, 8'h08, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0};
        vecs[6]  = '{1'b0, 8'h08, 8'h08, 8'h08, 8'h00, 1'b0, 3'd0, 1'b0};
        vecs[7]  = '{1'b0, 8'h08, 8'h08, 8'h00, 8'h00, 1'b1, 3'd3, 1'b0};
        vecs[8]  = '{1'b0, 8'h08, 8'h08, 8'h00, 8'h00, 1'b0, 3'd3, 1'b0};
        for (int i = 9; i <= 13; i++)
            vecs[i] = '{1'b0, 8'h00, 8'h08, 8'h00, 8'h00, 1'b0, 3'd3, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h08, 1'b0, 3'd3, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd3, 1'b0};

        #2;
        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst, vecs[i].pb);
            chk_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Glitch: pb[0] high for 3 cycles must never be accepted.
        for (int c = 0; c < 14; c++) begin
            step(1'b0, (c < 3) ? 8'h01 : 8'h00);
            chk($sformatf("glitch c%0d", c),
                32'({pb_level, pb_rise, pb_fall, key_strobe}), 32'(0));
        end

        // Bounce on pb[1]: 1,0,1,1,0,1 then steady 1.
        begin
            logic [5:0] pat;
            pat = 6'b101101;
            rises = 0; falls = 0; strobes = 0; seen_code = '0;
            for (int c = 0; c < 20; c++) begin
                step(1'b0, (c < 6) ? {6'b0, pat[5 - c], 1'b0} : 8'h02);
                if (pb_rise[1]) rises++;
                if (pb_fall[1]) falls++;
                if (key_strobe) begin strobes++; seen_code = key_code; end
            end
            chk("bounce rises",   32'(rises),     32'(1));
            chk("bounce falls",   32'(falls),     32'(0));
            chk("bounce strobes", 32'(strobes),   32'(1));
            chk("bounce code",    32'(seen_code), 32'(1));
            chk("bounce level",   32'(pb_level),  32'(8'h02));
        end

        // Simultaneous rise of pb[5] and pb[2] from a clean reset.
        step(1'b1, 8'h00);
        for (int c = 1; c <= 7; c++) begin
            step(1'b0, 8'h24);
            if (c < 6) begin
                chk($sformatf("simul c%0d rise", c), 32'(pb_rise), 32'(0));
            end else if (c == 6) begin
                chk("simul rise",  32'(pb_rise),  32'(8'h24));
                chk("simul level", 32'(pb_level), 32'(8'h24));
            end else begin
                chk("simul rise gone", 32'(pb_rise),    32'(0));
                chk("simul strobe",    32'(key_strobe), 32'(1));
                chk("simul code",      32'(key_code),   32'(2));
                chk("simul multi",     32'(key_multi),  32'(1));
            end
        end

        // Reset while cnt[4]==2 (after edge 4); pb[4] stays held throughout.
        for (int c = 1; c <= 4; c++) step(1'b0, 8'h10);
        step(1'b1, 8'h10);
        chk_all("rstmid", '{1'b1, 8'h10, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0});
        for (int c = 1; c <= 7; c++) begin
            step(1'b0, 8'h10);
            if (c < 6) begin
                chk($sformatf("rel c%0d", c), 32'({pb_level, pb_rise}), 32'(0));
            end else if (c == 6) begin
                chk("rel rise",  32'(pb_rise),  32'(8'h10));
                chk("rel level", 32'(pb_level), 32'(8'h10));
            end else begin
                chk("rel strobe", 32'(key_strobe), 32'(1));
                chk("rel code",   32'(key_code),   32'(4));
                chk("rel multi",  32'(key_multi),  32'(0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
